// File: rtl/conv_seq_ctrl.sv
// Job sequencer: walks image -> filters 0..F-1 for N images and answers write-block address requests.
// Latency: rd_init/wr_prim strobes 1 cycle after the triggering event; backpressure: none, pulse-driven handshake.
module conv_seq_ctrl #(
    parameter int ADDR_W     = 28,
    parameter int WORD_LEN   = 32,
    parameter int MAX_FLT    = 64,
    parameter int MAX_IMG    = 16,
    parameter int IMG_COLS   = 64,
    parameter int IMG_BASE   = 0,
    parameter int IMG_STRIDE = 4096,
    parameter int FLT_STRIDE = 9,
    parameter int OUT_BASE   = 0,
    localparam int FW = $clog2(MAX_FLT),
    localparam int IW = $clog2(MAX_IMG),
    localparam int ES = 32 / WORD_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_flt_base,
    input  logic [FW:0]       cfg_flt_num,
    input  logic [IW:0]       cfg_img_num,
    output logic [ADDR_W-1:0] rd_init_addr,
    output logic              rd_init_en,
    input  logic              rd_end,
    input  logic              pt_en,
    input  logic [5:0]        ptr,
    input  logic [5:0]        ptc,
    input  logic              wr_addr_rq,
    output logic [ADDR_W-1:0] wr_prim_addr,
    output logic              wr_prim_en,
    output logic [FW+ES-1:0]  wr_bias,
    output logic              busy,
    output logic [FW-1:0]     flt_idx,
    output logic [IW-1:0]     img_idx,
    output logic              conv_end
);
    localparam int EW = ADDR_W + 8;
    localparam logic [EW-1:0] IMG_BASE_E   = EW'(IMG_BASE);
    localparam logic [EW-1:0] IMG_STRIDE_E = EW'(IMG_STRIDE);
    localparam logic [EW-1:0] FLT_STRIDE_E = EW'(FLT_STRIDE);
    localparam logic [EW-1:0] OUT_BASE_E   = EW'(OUT_BASE);
    localparam logic [EW-1:0] IMG_COLS_E   = EW'(IMG_COLS);
    localparam logic [EW-1:0] IMG_PIX_E    = EW'(IMG_COLS * 64);
    localparam logic [EW-1:0] ES_E         = EW'(ES);

    typedef enum logic [1:0] {IDLE, RD_IMG, RD_FLT, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] flt_base_l;
    logic [FW:0]       flt_num_l;
    logic [IW:0]       img_num_l;
    logic [5:0]        ptr_l, ptc_l;

    logic [FW-1:0]     flt_idx_nxt;
    logic [IW-1:0]     img_idx_nxt;
    logic              rd_en_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic              load_cfg;

    logic [FW:0]       flt_inc;
    logic [IW:0]       img_inc;
    logic              last_flt, last_img, wr_active;
    logic [EW-1:0]     flt_addr_cur, flt_addr_inc, img_addr_inc, pix_e, wr_addr_e;

    assign flt_inc      = {1'b0, flt_idx} + (FW+1)'(1);
    assign img_inc      = {1'b0, img_idx} + (IW+1)'(1);
    assign last_flt     = (flt_inc == flt_num_l);
    assign last_img     = (img_inc == img_num_l);
    assign flt_addr_cur = EW'(flt_base_l) + EW'(flt_idx) * FLT_STRIDE_E;
    assign flt_addr_inc = EW'(flt_base_l) + EW'(flt_inc) * FLT_STRIDE_E;
    assign img_addr_inc = IMG_BASE_E + EW'(img_inc) * IMG_STRIDE_E;
    // Each pixel owns flt_num_l*ES words; the whole product wraps at ADDR_W.
    assign pix_e        = EW'(img_idx) * IMG_PIX_E + EW'(ptr_l) * IMG_COLS_E + EW'(ptc_l);
    assign wr_addr_e    = OUT_BASE_E + pix_e * EW'(flt_num_l) * ES_E;
    assign wr_active    = (state == RD_IMG) || (state == RD_FLT);
    assign busy         = (state != IDLE);
    assign conv_end     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        flt_idx_nxt = flt_idx;
        img_idx_nxt = img_idx;
        rd_en_nxt   = 1'b0;
        rd_addr_nxt = rd_init_addr;
        load_cfg    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_cfg    = 1'b1;
                    flt_idx_nxt = '0;
                    img_idx_nxt = '0;
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = ADDR_W'(IMG_BASE);
                    state_nxt   = RD_IMG;
                end
            end
            RD_IMG: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (rd_end) begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = flt_addr_cur[ADDR_W-1:0];
                    state_nxt   = RD_FLT;
                end
            end
            RD_FLT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (rd_end) begin
                    if (!last_flt) begin
                        flt_idx_nxt = flt_inc[FW-1:0];
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = flt_addr_inc[ADDR_W-1:0];
                    end else if (!last_img) begin
                        flt_idx_nxt = '0;
                        img_idx_nxt = img_inc[IW-1:0];
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = img_addr_inc[ADDR_W-1:0];
                        state_nxt   = RD_IMG;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flt_idx      <= '0;
            img_idx      <= '0;
            rd_init_en   <= 1'b0;
            rd_init_addr <= '0;
            flt_base_l   <= '0;
            flt_num_l    <= '0;
            img_num_l    <= '0;
            ptr_l        <= '0;
            ptc_l        <= '0;
            wr_prim_en   <= 1'b0;
            wr_prim_addr <= '0;
            wr_bias      <= '0;
        end else begin
            flt_idx      <= flt_idx_nxt;
            img_idx      <= img_idx_nxt;
            rd_init_en   <= rd_en_nxt;
            rd_init_addr <= rd_addr_nxt;
            if (load_cfg) begin
                flt_base_l <= cfg_flt_base;
                flt_num_l  <= (cfg_flt_num == '0) ? (FW+1)'(MAX_FLT) : cfg_flt_num;
                img_num_l  <= (cfg_img_num == '0) ? (IW+1)'(MAX_IMG) : cfg_img_num;
            end
            if (pt_en) begin
                ptr_l <= ptr;
                ptc_l <= ptc;
            end
            // Registered from current state, so same-cycle rd_end/pt_en updates are not yet visible.
            wr_prim_en <= wr_active && wr_addr_rq;
            if (wr_active && wr_addr_rq) begin
                wr_prim_addr <= wr_addr_e[ADDR_W-1:0];
                wr_bias      <= (FW+ES)'(flt_idx) * (FW+ES)'(ES);
            end
        end
    end
endmodule
